// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_pkg
// Purpose  : Shared constants and elaboration-time helpers for the pipelined
//            accumulating adder tree.
//            F_NBITS_DEFAULT   default field-element width
//            PRIME             2^F_NBITS_DEFAULT - 1 (Mersenne modulus)
//            nlevels()         tree depth, clog2(ngates) with a floor of 1
//            lvl_num_inputs()  number of operands entering a given level
// Config   : ADDER_TREE_MODRED_EN (used by field_adder)
// Revision : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

  localparam int F_NBITS_DEFAULT = 61;
  localparam logic [F_NBITS_DEFAULT-1:0] PRIME = {F_NBITS_DEFAULT{1'b1}};

  // Depth of the tree; a single-input tree still gets one register stage so
  // that latency stays NLEVELS+1 for every NGATES.
  function automatic int nlevels(input int ngates);
    int l;
    l = 0;
    while ((1 << l) < ngates) l++;
    if (l < 1) l = 1;
    return l;
  endfunction

  // Operand count at the input of 'level' (level 0 = the raw beat). Each
  // level halves the count, rounding up for the odd pass-through operand.
  function automatic int lvl_num_inputs(input int level, input int ngates);
    int n;
    n = ngates;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_accum_adder_tree_field_adder.sv
`default_nettype none
// ============================================================================
// Module   : field_adder
// Purpose  : Combinational two-operand field adder.
//            ADDER_TREE_MODRED_EN defined   : sum mod 2^F_NBITS-1 (canonical)
//            ADDER_TREE_MODRED_EN undefined : sum wraps mod 2^F_NBITS
// Ports    : i_a, i_b  operands (F_NBITS)
//            o_sum     result   (F_NBITS)
// Revision : 1.0 - initial release
// ============================================================================
module field_adder
  import adder_tree_pkg::*;
#(
  parameter int F_NBITS = F_NBITS_DEFAULT
) (
  input  logic [F_NBITS-1:0] i_a,
  input  logic [F_NBITS-1:0] i_b,
  output logic [F_NBITS-1:0] o_sum
);

`ifdef ADDER_TREE_MODRED_EN
  logic [F_NBITS:0]   w_s;
  logic [F_NBITS-1:0] w_r;

  // Folding the carry back in is exact for a Mersenne modulus; the fold can
  // land on p itself, which is the non-canonical form of zero.
  assign w_s   = {1'b0, i_a} + {1'b0, i_b};
  assign w_r   = w_s[F_NBITS-1:0] + F_NBITS'(w_s[F_NBITS]);
  assign o_sum = (w_r == {F_NBITS{1'b1}}) ? '0 : w_r;
`else
  assign o_sum = i_a + i_b;
`endif

endmodule
`default_nettype wire

// File: rtl/pipelined_accum_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_accum_adder_tree
// Purpose  : Pipelined binary adder tree over NGATES field elements per beat,
//            followed by a group accumulator. One register stage per tree
//            level plus the accumulator stage (latency NLEVELS+1).
// Ports    : clk, rst        clock, asynchronous active-high reset
//            in_valid/ready  input handshake for one beat on v_parts
//            in_last         final beat of the current group
//            v_parts[NGATES] addends
//            out_valid/ready output handshake for the group sum v
// Config   : ADDER_TREE_MODRED_EN selects mod 2^F_NBITS-1 arithmetic
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_accum_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int NGATES  = 8,
  parameter int F_NBITS = F_NBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [F_NBITS-1:0] v_parts [NGATES],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [F_NBITS-1:0] v
);

  localparam int NLEVELS = nlevels(NGATES);

  logic w_stall;

  // A held result freezes the whole pipe, so back-pressure reaches the input
  // in the same cycle and nothing inside can be overwritten.
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  // --------------------------------------------------------------------------
  // Tree levels
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NLEVELS; k++) begin : g_lvl
    localparam int NIN  = lvl_num_inputs(k, NGATES);
    localparam int NOUT = lvl_num_inputs(k + 1, NGATES);

    logic [F_NBITS-1:0] w_in  [NIN];
    logic [F_NBITS-1:0] w_sum [NOUT];
    logic [F_NBITS-1:0] r_q   [NOUT];
    logic               w_vld;
    logic               w_lst;
    logic               r_vld;
    logic               r_lst;

    if (k == 0) begin : g_src_in
      for (genvar j = 0; j < NIN; j++) begin : g_cp
        assign w_in[j] = v_parts[j];
      end
      assign w_vld = in_valid && in_ready;
      assign w_lst = in_last;
    end else begin : g_src_prev
      for (genvar j = 0; j < NIN; j++) begin : g_cp
        assign w_in[j] = g_lvl[k-1].r_q[j];
      end
      assign w_vld = g_lvl[k-1].r_vld;
      assign w_lst = g_lvl[k-1].r_lst;
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_node
      if (2*j + 1 < NIN) begin : g_add
        field_adder #(.F_NBITS(F_NBITS)) u_add (
          .i_a   (w_in[2*j]),
          .i_b   (w_in[2*j+1]),
          .o_sum (w_sum[j])
        );
      end else begin : g_pass
        // Odd leftover operand rides through this level untouched.
        assign w_sum[j] = w_in[2*j];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_lst <= 1'b0;
        for (int j = 0; j < NOUT; j++) r_q[j] <= '0;
      end else if (!w_stall) begin
        r_vld <= w_vld;
        r_lst <= w_lst;
        for (int j = 0; j < NOUT; j++) r_q[j] <= w_sum[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator stage
  // --------------------------------------------------------------------------
  logic [F_NBITS-1:0] w_tree_sum;
  logic               w_tree_vld;
  logic               w_tree_lst;
  logic [F_NBITS-1:0] w_acc_base;
  logic [F_NBITS-1:0] w_acc_next;
  logic [F_NBITS-1:0] r_acc;
  logic [F_NBITS-1:0] r_v;
  logic               r_first;
  logic               r_out_valid;

  assign w_tree_sum = g_lvl[NLEVELS-1].r_q[0];
  assign w_tree_vld = g_lvl[NLEVELS-1].r_vld;
  assign w_tree_lst = g_lvl[NLEVELS-1].r_lst;

  // The first beat of a group ignores whatever the previous group left in
  // r_acc, so no separate clear cycle is needed between groups.
  assign w_acc_base = r_first ? '0 : r_acc;

  field_adder #(.F_NBITS(F_NBITS)) u_acc_add (
    .i_a   (w_acc_base),
    .i_b   (w_tree_sum),
    .o_sum (w_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_v         <= '0;
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      // Not stalled means any pending result is being consumed this edge,
      // so out_valid simply follows whether a new group completes now.
      r_out_valid <= w_tree_vld && w_tree_lst;
      if (w_tree_vld) begin
        r_acc   <= w_acc_next;
        r_first <= w_tree_lst;
        if (w_tree_lst) r_v <= w_acc_next;
      end
    end
  end

  assign v         = r_v;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_accum_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_accum_adder_tree
// Purpose  : Self-checking bench. Instance A (NGATES=8) runs the directed
//            cases, instance B (NGATES=237) runs random groups under random
//            back-pressure. Expected group sums are queued when the last
//            beat is accepted and compared when the DUT hands a result out.
// Config   : ADDER_TREE_MODRED_EN selects the modular reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_accum_adder_tree;
  import adder_tree_pkg::*;

  localparam int NA = 8;
  localparam int NB = 237;

`ifdef ADDER_TREE_MODRED_EN
  localparam logic [60:0] EXP31 = 61'h1FFF_FFFF_FFFF_FFF7;
`else
  localparam logic [60:0] EXP31 = 61'h1FFF_FFFF_FFFF_FFF0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_last, a_oready, a_iready, a_ovalid;
  logic [60:0] a_parts [NA];
  logic [60:0] a_v;
  logic        b_valid, b_last, b_oready, b_iready, b_ovalid;
  logic [60:0] b_parts [NB];
  logic [60:0] b_v;

  pipelined_accum_adder_tree #(.NGATES(NA), .F_NBITS(61)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_iready),
    .in_last(a_last), .v_parts(a_parts), .out_valid(a_ovalid),
    .out_ready(a_oready), .v(a_v)
  );

  pipelined_accum_adder_tree #(.NGATES(NB), .F_NBITS(61)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_iready),
    .in_last(b_last), .v_parts(b_parts), .out_valid(b_ovalid),
    .out_ready(b_oready), .v(b_v)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference field addition, written as a true modulo rather than a fold.
  function automatic logic [60:0] fadd(input logic [60:0] a, input logic [60:0] b);
    logic [63:0] s;
    s = {3'b0, a} + {3'b0, b};
`ifdef ADDER_TREE_MODRED_EN
    return 61'(s % {3'b0, PRIME});
`else
    return s[60:0];
`endif
  endfunction

  // Scoreboards and per-instance group models
  logic [60:0] q_a [$];
  logic [60:0] q_b [$];
  logic [60:0] m_a_acc, m_b_acc;
  bit          m_a_first = 1'b1;
  bit          m_b_first = 1'b1;

  // Caller must be sitting on a negedge; returns on the negedge after the
  // accepting edge with the beat still driven (back-to-back is possible).
  task automatic send_a(input logic [60:0] p [NA], input bit last,
                        input bit ovr, input logic [60:0] ovr_val);
    int n;
    logic [60:0] ts;
    a_parts = p; a_valid = 1'b1; a_last = last;
    #2;
    n = 0;
    while (a_iready !== 1'b1 && n < 200) begin @(negedge clk); #2; n++; end
    if (n >= 200) chk("a_ready_timeout", {63'b0, a_iready}, 64'd1);
    @(posedge clk);
    ts = '0;
    for (int i = 0; i < NA; i++) ts = fadd(ts, p[i]);
    m_a_acc   = fadd(m_a_first ? 61'd0 : m_a_acc, ts);
    m_a_first = last;
    if (last) q_a.push_back(ovr ? ovr_val : m_a_acc);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [60:0] p [NB], input bit last);
    int n;
    logic [60:0] ts;
    b_parts = p; b_valid = 1'b1; b_last = last;
    #2;
    n = 0;
    while (b_iready !== 1'b1 && n < 200) begin @(negedge clk); #2; n++; end
    if (n >= 200) chk("b_ready_timeout", {63'b0, b_iready}, 64'd1);
    @(posedge clk);
    ts = '0;
    for (int i = 0; i < NB; i++) ts = fadd(ts, p[i]);
    m_b_acc   = fadd(m_b_first ? 61'd0 : m_b_acc, ts);
    m_b_first = last;
    if (last) q_b.push_back(m_b_acc);
    @(negedge clk);
  endtask

  task automatic drain(input bit which_b);
    int n;
    n = 0;
    while ((which_b ? q_b.size() : q_a.size()) != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (which_b) chk("b_drain", 64'(q_b.size()), 64'd0);
    else         chk("a_drain", 64'(q_a.size()), 64'd0);
    @(negedge clk);
  endtask

  // Output monitor: sampled mid-cycle, after all negedge drives settle.
  bit          a_stall_prev = 1'b0;
  logic [60:0] a_v_prev;
  int          a_pop_last = 0;
  int          a_pop_prev = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      a_stall_prev = 1'b0;
    end else begin
      chk("a_in_ready", {63'b0, a_iready}, {63'b0, !(a_ovalid && !a_oready)});
      if (a_stall_prev) begin
        chk("a_hold_v", {3'b0, a_v}, {3'b0, a_v_prev});
        chk("a_hold_ovalid", {63'b0, a_ovalid}, 64'd1);
      end
      if (a_ovalid && a_oready) begin
        if (q_a.size() == 0) chk("a_unexpected", {63'b0, a_ovalid}, 64'd0);
        else begin
          chk("a_v", {3'b0, a_v}, {3'b0, q_a.pop_front()});
          a_pop_prev = a_pop_last;
          a_pop_last = cyc;
        end
      end
      a_stall_prev = a_ovalid && !a_oready;
      a_v_prev     = a_v;
      if (b_ovalid && b_oready) begin
        if (q_b.size() == 0) chk("b_unexpected", {63'b0, b_ovalid}, 64'd0);
        else chk("b_v", {3'b0, b_v}, {3'b0, q_b.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit b_run = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (b_run) b_oready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [60:0] p [NA];
    logic [60:0] pb [NB];

    rst = 1'b1;
    a_valid = 1'b0; a_last = 1'b0; a_oready = 1'b1;
    b_valid = 1'b0; b_last = 1'b0; b_oready = 1'b1;
    for (int i = 0; i < NA; i++) a_parts[i] = '0;
    for (int i = 0; i < NB; i++) b_parts[i] = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_a_v", {3'b0, a_v}, 64'd0);
    chk("rst_a_ovalid", {63'b0, a_ovalid}, 64'd0);
    chk("rst_b_v", {3'b0, b_v}, 64'd0);
    chk("rst_b_ovalid", {63'b0, b_ovalid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("a_ready_after_rst", {63'b0, a_iready}, 64'd1);
    chk("b_ready_after_rst", {63'b0, b_iready}, 64'd1);
    @(negedge clk);

    // One-beat group 1..8 -> 36, out_valid exactly 4 cycles after acceptance
    for (int i = 0; i < NA; i++) p[i] = 61'(i + 1);
    send_a(p, 1'b1, 1'b1, 61'd36);
    a_valid = 1'b0; a_last = 1'b0;
    #2 chk("lat_c1", {63'b0, a_ovalid}, 64'd0);
    @(negedge clk); #2 chk("lat_c2", {63'b0, a_ovalid}, 64'd0);
    @(negedge clk); #2 chk("lat_c3", {63'b0, a_ovalid}, 64'd0);
    @(negedge clk); #2 chk("lat_c4", {63'b0, a_ovalid}, 64'd1);
    @(negedge clk);
    drain(1'b0);

    // All inputs 2^61-2
    for (int i = 0; i < NA; i++) p[i] = 61'h1FFF_FFFF_FFFF_FFFE;
    send_a(p, 1'b1, 1'b1, EXP31);
    a_valid = 1'b0;
    drain(1'b0);

    // Three-beat group of ones then an immediate one-beat group
    for (int i = 0; i < NA; i++) p[i] = 61'd1;
    send_a(p, 1'b0, 1'b0, 61'd0);
    send_a(p, 1'b0, 1'b0, 61'd0);
    send_a(p, 1'b1, 1'b1, 61'd24);
    send_a(p, 1'b1, 1'b1, 61'd8);
    a_valid = 1'b0; a_last = 1'b0;
    drain(1'b0);
    chk("a_consecutive", 64'(a_pop_last - a_pop_prev), 64'd1);

    // Streaming with a 5-cycle out_ready drop
    fork
      begin
        for (int g = 0; g < 6; g++) begin
          for (int bt = 0; bt < 2; bt++) begin
            for (int i = 0; i < NA; i++) p[i] = {29'b0, $urandom()};
            send_a(p, bt == 1, 1'b0, 61'd0);
          end
        end
        a_valid = 1'b0; a_last = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        a_oready = 1'b0;
        repeat (5) @(negedge clk);
        a_oready = 1'b1;
      end
    join
    drain(1'b0);

    // Reset while the second beat of a group is in the tree
    for (int i = 0; i < NA; i++) p[i] = {29'b0, $urandom()};
    send_a(p, 1'b0, 1'b0, 61'd0);
    send_a(p, 1'b0, 1'b0, 61'd0);
    a_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ovalid", {63'b0, a_ovalid}, 64'd0);
    chk("mid_rst_v", {3'b0, a_v}, 64'd0);
    #1 rst = 1'b0;
    m_a_first = 1'b1;
    m_b_first = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2 chk("post_rst_idle", {63'b0, a_ovalid}, 64'd0);
    end
    @(negedge clk);
    for (int i = 0; i < NA; i++) p[i] = 61'(i + 1);
    send_a(p, 1'b1, 1'b1, 61'd36);
    a_valid = 1'b0; a_last = 1'b0;
    drain(1'b0);

    // NGATES=237: 50 random groups of 1-4 beats under random back-pressure
    b_run = 1'b1;
    for (int g = 0; g < 50; g++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int bt = 0; bt < nb; bt++) begin
        for (int i = 0; i < NB; i++) pb[i] = {29'b0, $urandom()};
        send_b(pb, bt == nb - 1);
      end
    end
    b_valid = 1'b0; b_last = 1'b0;
    b_run = 1'b0;
    @(negedge clk);
    b_oready = 1'b1;
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_accum_adder_tree.md
PIPELINED_ACCUM_ADDER_TREE -- requirements
Module: pipelined_accum_adder_tree

Interface
REQ-001 Parameter NGATES, default 8, meaning number of field-element inputs per beat (1..1024).
REQ-002 Parameter F_NBITS, default 61, meaning width of each field element.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  beat present on v_parts.
REQ-006 Port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 Port in_last  input  1  final beat of the current accumulation group.
REQ-008 Port v_parts  input  F_NBITS x NGATES  unpacked array of addends, element i at index i.
REQ-009 Port out_valid  output  1  v holds a completed group sum.
REQ-010 Port out_ready  input  1  consumer accepts v when out_valid && out_ready.
REQ-011 Port v  output  F_NBITS  group sum.

Function
REQ-012 NLEVELS = clog2(NGATES), with a minimum of 1; the tree SHALL have one register stage per level.
REQ-013 Level k pairs inputs (2j, 2j+1) into field_adder outputs; an odd final input passes through unmodified to index ni/2.
REQ-014 Each stage SHALL carry a valid bit and a last bit alongside its data.
REQ-015 Accumulator stage after the tree: on a valid beat, acc = (first ? 0 : acc) + tree_sum; first is set after reset and after every last beat.
REQ-016 A valid beat with last=1 SHALL load v with the new acc and set out_valid in the same edge.
REQ-017 Latency from accepted beat with in_last=1 to out_valid = NLEVELS+1 cycles.
REQ-018 stall = out_valid && !out_ready; in_ready = !stall; while stall, all stages, valids and acc hold.
REQ-019 out_valid clears on the handshake edge unless a new last beat arrives on the same edge, in which case v reloads and out_valid stays high; no bubble is required.
REQ-020 Throughput: one beat per cycle when out_ready is held high.
REQ-021 A group of one beat (in_last on the first beat) SHALL be legal; the result equals the tree sum.
REQ-022 v, in_ready and out_valid SHALL never be X after reset, including while no beat is in flight.

Reset
REQ-023 rst SHALL asynchronously clear all stage valids, out_valid, acc and v to 0, and set first=1.
REQ-024 rst mid-group SHALL discard partial sums; the next accepted beat starts a new group.
REQ-025 in_ready SHALL be 1 while rst is deasserted and no stall is present.

Configuration
REQ-026 With ADDER_TREE_MODRED_EN defined, every addition SHALL be mod p = 2^F_NBITS-1: s = a+b; r = s[F_NBITS-1:0] + s[F_NBITS]; r == p maps to 0.
REQ-027 With ADDER_TREE_MODRED_EN undefined, additions SHALL wrap mod 2^F_NBITS with no reduction logic.

Structure
REQ-028 The shared package adder_tree_pkg SHALL hold the F_NBITS default, the PRIME constant, the function lvl_num_inputs(level, ngates), and the nlevels computation.
REQ-029 The sub-module field_adder is a combinational two-input adder; it contains all ADDER_TREE_MODRED_EN logic and is instantiated in the tree and in the accumulator.

Verification
REQ-030 NGATES=8, v_parts=1..8, in_last=1, out_ready=1 -> v=36 with out_valid high exactly 4 cycles after acceptance.
REQ-031 NGATES=8, all inputs 2^61-2 -> with MODRED v=2^61-9; without MODRED v=2^61-16.
REQ-032 NGATES=237, 50 random groups of 1-4 beats with 32-bit random inputs -> every v matches the reference model and results arrive in order.
REQ-033 NGATES=8, all inputs 1, three beats with in_last on the third, then an immediate one-beat group -> v=24 then v=8 on consecutive out_valid cycles.
REQ-034 Back-to-back streaming with out_ready=0 for 5 cycles -> in_ready low within the same cycle; no result is lost, duplicated or altered; flow resumes after out_ready=1.
REQ-035 rst pulse while the second beat of a group is in the tree -> all valids clear; the following one-beat group of 1..8 yields v=36.
